// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle of the BCD countdown timer.
// The host drives controls through master; the timer exposes its digits through slave.
interface bcd_countdown_timer_if;
  logic        clear;
  logic        run;
  logic [5:0]  set_sel;
  logic        set_inc;
  logic        reload_mode;
  logic [11:0] milli_o;
  logic [7:0]  seconds_o;
  logic [7:0]  minutes_o;
  logic [7:0]  hours_o;
  logic        running_o;
  logic        expired_o;

  modport master (
    output clear, run, set_sel, set_inc, reload_mode,
    input  milli_o, seconds_o, minutes_o, hours_o, running_o, expired_o
  );

  modport slave (
    input  clear, run, set_sel, set_inc, reload_mode,
    output milli_o, seconds_o, minutes_o, hours_o, running_o, expired_o
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// HH:MM:SS.mmm BCD countdown timer with digit-set, pause, one-shot and auto-reload.
// The time register packs nine BCD digits: {h1,h0,m1,m0,s1,s0,ms2,ms1,ms0}.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 100000,
  parameter int DIV_W    = $clog2(TICK_DIV)
) (
  input logic                  clk,
  input logic                  resetn,
  bcd_countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  function automatic logic [3:0] inc_wrap(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : (d + 4'd1);
  endfunction

  // Value a digit takes when it borrows; digit 8 (hour tens) never borrows on a non-zero count.
  function automatic logic [3:0] dig_max(input int idx);
    case (idx)
      4, 6:    return 4'd5;
      8:       return 4'd2;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [35:0] bcd_dec(input logic [35:0] v);
    logic [35:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = dig_max(i);
          borrow      = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  state_t           r_state;
  logic [35:0]      r_time;
  logic [23:0]      r_reload;
  logic [DIV_W-1:0] r_div;
  logic             r_inc_d;
  logic             r_running;
  logic             r_expired;

  state_t           w_state_nx;
  logic [35:0]      w_time_nx;
  logic [23:0]      w_reload_nx;
  logic [DIV_W-1:0] w_div_nx;
  logic             w_exp_nx;
  logic [23:0]      w_set_hms;
  logic             w_onehot;
  logic             w_set_ok;
  logic             w_tick;
  logic             w_nonzero;

  assign w_onehot  = (bus.set_sel != 6'd0) && ((bus.set_sel & (bus.set_sel - 6'd1)) == 6'd0);
  assign w_set_ok  = ((r_state == IDLE) || (r_state == PAUSE)) && w_onehot &&
                     bus.set_inc && !r_inc_d;
  assign w_tick    = (r_div == DIV_LAST);
  assign w_nonzero = (r_time != 36'd0);

  // HH:MM:SS after incrementing the selected digit, including the hour-tens clamp.
  always_comb begin
    w_set_hms = r_time[35:12];
    case (bus.set_sel)
      6'b000001: w_set_hms[3:0]   = inc_wrap(r_time[15:12], 4'd9);
      6'b000010: w_set_hms[7:4]   = inc_wrap(r_time[19:16], 4'd5);
      6'b000100: w_set_hms[11:8]  = inc_wrap(r_time[23:20], 4'd9);
      6'b001000: w_set_hms[15:12] = inc_wrap(r_time[27:24], 4'd5);
      6'b010000: w_set_hms[19:16] = inc_wrap(r_time[31:28],
                                             (r_time[35:32] == 4'd2) ? 4'd3 : 4'd9);
      6'b100000: begin
        w_set_hms[23:20] = inc_wrap(r_time[35:32], 4'd2);
        if ((w_set_hms[23:20] == 4'd2) && (r_time[31:28] > 4'd3)) begin
          w_set_hms[19:16] = 4'd3;
        end else begin
          w_set_hms[19:16] = r_time[31:28];
        end
      end
      default:   w_set_hms = r_time[35:12];
    endcase
  end

  // Next-state logic, priority clear > set > run control > tick.
  always_comb begin
    w_state_nx  = r_state;
    w_time_nx   = r_time;
    w_reload_nx = r_reload;
    w_div_nx    = r_div;
    w_exp_nx    = 1'b0;
    if (bus.clear) begin
      w_state_nx = IDLE;
      w_time_nx  = 36'd0;
      w_div_nx   = {DIV_W{1'b0}};
    end else if (w_set_ok) begin
      w_time_nx   = {w_set_hms, 12'h000};
      w_reload_nx = w_set_hms;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.run && w_nonzero) begin
            w_state_nx = RUN;
            w_div_nx   = {DIV_W{1'b0}};
          end else begin
            w_state_nx = IDLE;
          end
        end
        RUN: begin
          if (!bus.run) begin
            w_state_nx = PAUSE;
          end else if (w_tick) begin
            w_div_nx = {DIV_W{1'b0}};
            if (r_time == 36'h000000001) begin
              w_exp_nx = 1'b1;
              // Reload mode is sampled here so a mid-run change applies at this expiry.
              if (bus.reload_mode && (r_reload != 24'd0)) begin
                w_time_nx = {r_reload, 12'h000};
              end else begin
                w_time_nx  = 36'd0;
                w_state_nx = DONE;
              end
            end else begin
              w_time_nx = bcd_dec(r_time);
            end
          end else begin
            w_div_nx = r_div + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (bus.run) begin
            w_state_nx = RUN;
          end else begin
            w_state_nx = PAUSE;
          end
        end
        DONE: begin
          if (!bus.run) begin
            w_state_nx = IDLE;
          end else begin
            w_state_nx = DONE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // State, digits, reload, prescaler and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_time    <= 36'd0;
      r_reload  <= 24'd0;
      r_div     <= {DIV_W{1'b0}};
      r_inc_d   <= 1'b0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_time    <= w_time_nx;
      r_reload  <= w_reload_nx;
      r_div     <= w_div_nx;
      r_inc_d   <= bus.set_inc;
      r_running <= (w_state_nx == RUN);
      r_expired <= w_exp_nx;
    end
  end

  assign bus.hours_o   = r_time[35:28];
  assign bus.minutes_o = r_time[27:20];
  assign bus.seconds_o = r_time[19:12];
  assign bus.milli_o   = r_time[11:0];
  assign bus.running_o = r_running;
  assign bus.expired_o = r_expired;

endmodule
